// File: rtl/myproject_sdiv_pkg.sv
// rtl/myproject_sdiv_pkg.sv - shared state encoding and defaults for the sequential signed divider
package myproject_sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sdiv_state_t;

  localparam int SDIV_W_DEF = 8;
  localparam int SDIV_D_DEF = 5;

endpackage

// File: rtl/myproject_sdiv_step.sv
// rtl/myproject_sdiv_step.sv - one restoring-division step on unsigned magnitudes
module myproject_sdiv_step #(
  parameter int D = 5
) (
  input  logic [D-1:0] prem,
  input  logic         din_bit,
  input  logic [D-1:0] divisor,
  output logic [D:0]   new_rem,
  output logic         qbit
);

  logic [D:0] shifted;
  logic [D:0] diff;
  logic       borrow;

  always_comb begin
    shifted          = {prem, din_bit};
    {borrow, diff}   = {1'b0, shifted} - {2'b00, divisor};
    qbit             = ~borrow;
    // Restore on borrow; either way the result is below the divisor, so bit D is 0.
    new_rem          = borrow ? shifted : diff;
  end

endmodule

// File: rtl/myproject_sdiv_8s_5ns_seq.sv
// rtl/myproject_sdiv_8s_5ns_seq.sv - signed / unsigned sequential restoring divider, start/done handshake
module myproject_sdiv_8s_5ns_seq
  import myproject_sdiv_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = SDIV_W_DEF,
  parameter int din1_WIDTH = SDIV_D_DEF,
  parameter int rem_WIDTH  = SDIV_D_DEF + 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic [din0_WIDTH-1:0] quot,
  output logic [rem_WIDTH-1:0]  rem,
  output logic                  div_by_zero
);

  localparam int W  = din0_WIDTH;
  localparam int D  = din1_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] Q_POS_SAT = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_NEG_SAT = {1'b1, {(W-1){1'b0}}};

  if (rem_WIDTH != D + 1) begin : g_bad_rem_width
    $error("sdiv instance %0d: rem_WIDTH must be din1_WIDTH+1", ID);
  end

  sdiv_state_t    state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   dvd;
  logic [D-1:0]   prem;
  logic [D-1:0]   divisor;
  logic           neg;
  logic           dz;

  logic [D:0]     nrem;
  logic           qbit;
  logic [W-1:0]   din0_mag;
  logic [W-1:0]   q_mag;

  myproject_sdiv_step #(.D(D)) u_step (
    .prem    (prem),
    .din_bit (dvd[W-1]),
    .divisor (divisor),
    .new_rem (nrem),
    .qbit    (qbit)
  );

  // W-bit unsigned magnitude: -2^(W-1) maps to 2^(W-1) without overflow.
  assign din0_mag = din0[W-1] ? -din0 : din0;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign q_mag    = {dvd[W-2:0], qbit};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      prem        <= '0;
      divisor     <= '0;
      neg         <= 1'b0;
      dz          <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      ap_done     <= 1'b0;
      ap_ready    <= 1'b0;
      ap_idle     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          if (ap_start) begin
            dvd     <= din0_mag;
            prem    <= '0;
            divisor <= din1;
            neg     <= din0[W-1];
            dz      <= (din1 == '0);
            cnt     <= CW'(W - 1);
            state   <= CALC;
            ap_idle <= 1'b0;
          end
        end
        CALC: begin
          dvd  <= q_mag;
          prem <= nrem[D-1:0];
          if (cnt == '0) begin
            state       <= DONE;
            ap_done     <= 1'b1;
            ap_ready    <= 1'b1;
            div_by_zero <= dz;
            if (dz) begin
              quot <= neg ? Q_NEG_SAT : Q_POS_SAT;
              rem  <= '0;
            end else begin
              quot <= neg ? -q_mag : q_mag;
              rem  <= neg ? -nrem : nrem;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          ap_idle  <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          ap_idle  <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_8s_5ns_seq.sv
// tb/tb_myproject_sdiv_8s_5ns_seq.sv - scoreboard bench for the sequential signed divider
module tb_myproject_sdiv_8s_5ns_seq;

  logic       ap_clk = 1'b0;
  logic       ap_rst = 1'b1;
  logic       ap_start = 1'b0;
  logic [7:0] din0 = '0;
  logic [4:0] din1 = '0;
  logic       ap_idle, ap_ready, ap_done, div_by_zero;
  logic [7:0] quot;
  logic [5:0] rem;

  myproject_sdiv_8s_5ns_seq #(
    .ID(1), .din0_WIDTH(8), .din1_WIDTH(5), .rem_WIDTH(6)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .din0        (din0),
    .din1        (din1),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [7:0] q;
    logic [5:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [4:0] b);
    exp_t m;
    int ai, bi, qi, ri;
    ai = $signed(a);
    bi = int'(b);
    if (bi == 0) begin
      m.q = (ai >= 0) ? 8'h7f : 8'h80;
      m.r = 6'd0;
      m.z = 1'b1;
    end else begin
      qi  = ai / bi;
      ri  = ai % bi;
      m.q = 8'(qi);
      m.r = 6'(ri);
      m.z = 1'b0;
    end
    return m;
  endfunction

  always @(negedge ap_clk) begin
    if (!ap_rst && (ap_done || ap_ready)) begin
      check_val("ready_eq_done", 32'(ap_ready), 32'(ap_done));
      if (ap_done) begin
        if (sb.size() == 0) begin
          check_val("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("quot", 32'(quot), 32'(e.q));
          check_val("rem", 32'(rem), 32'(e.r));
          check_val("div_by_zero", 32'(div_by_zero), 32'(e.z));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!ap_idle && n < 30) begin
      @(negedge ap_clk);
      n++;
    end
    if (!ap_idle) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_div(input logic [7:0] a, input logic [4:0] b);
    int  n;
    int  lat;
    wait_idle();
    din0     = a;
    din1     = b;
    ap_start = 1'b1;
    sb.push_back(model(a, b));
    lat = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
      din0     = 8'($urandom);
      din1     = 5'($urandom);
      if (ap_done) begin
        lat = n;
        break;
      end
    end
    check_val("latency", 32'(lat), 32'd9);
  endtask

  initial begin
    int dones[$];
    logic [7:0] corners_a [4];
    logic [4:0] corners_b [3];

    repeat (3) @(negedge ap_clk);
    check_val("rst_quot", 32'(quot), 32'd0);
    check_val("rst_rem", 32'(rem), 32'd0);
    check_val("rst_dbz", 32'(div_by_zero), 32'd0);
    check_val("rst_done", 32'(ap_done), 32'd0);
    check_val("rst_ready", 32'(ap_ready), 32'd0);
    check_val("rst_idle", 32'(ap_idle), 32'd1);
    ap_rst = 1'b0;
    @(negedge ap_clk);

    do_div(8'd100, 5'd7);
    do_div(-8'sd100, 5'd7);
    do_div(8'h80, 5'd1);
    do_div(8'd127, 5'd31);
    do_div(8'd5, 5'd31);
    do_div(8'd50, 5'd0);
    do_div(-8'sd50, 5'd0);

    // Held start: one completion every 10 cycles, operands scrambled between acceptances.
    wait_idle();
    for (int k = 0; k < 3; k++) sb.push_back(model(8'd9, 5'd2));
    for (int k = 0; k < 30; k++) begin
      if (k % 10 == 0) begin
        din0 = 8'd9;
        din1 = 5'd2;
      end else begin
        din0 = 8'($urandom);
        din1 = 5'($urandom);
      end
      ap_start = 1'b1;
      @(negedge ap_clk);
      if (ap_done) dones.push_back(k + 1);
      check_val("held_idle", 32'(ap_idle), 32'((k + 1) % 10 == 0));
      if (k + 1 == 10) check_val("held_quot_hold", 32'(quot), 32'd4);
    end
    ap_start = 1'b0;
    check_val("held_done_count", 32'(dones.size()), 32'd3);
    if (dones.size() == 3) begin
      check_val("held_done0", 32'(dones[0]), 32'd9);
      check_val("held_done1", 32'(dones[1]), 32'd19);
      check_val("held_done2", 32'(dones[2]), 32'd29);
    end

    // Asynchronous reset three cycles into CALC aborts without a completion.
    do_div(8'd100, 5'd7);
    wait_idle();
    din0     = 8'd50;
    din1     = 5'd3;
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (3) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    check_val("abort_quot", 32'(quot), 32'd0);
    check_val("abort_rem", 32'(rem), 32'd0);
    check_val("abort_dbz", 32'(div_by_zero), 32'd0);
    check_val("abort_idle", 32'(ap_idle), 32'd1);
    check_val("abort_done", 32'(ap_done), 32'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (15) @(negedge ap_clk);
    check_val("abort_idle_after", 32'(ap_idle), 32'd1);
    do_div(-8'sd7, 5'd2);

    corners_a[0] = 8'h80; corners_a[1] = 8'hff; corners_a[2] = 8'h00; corners_a[3] = 8'h7f;
    corners_b[0] = 5'd0;  corners_b[1] = 5'd1;  corners_b[2] = 5'd31;
    foreach (corners_a[i]) foreach (corners_b[j]) do_div(corners_a[i], corners_b[j]);

    for (int i = 0; i < 1500; i++) do_div(8'($urandom), 5'($urandom));

    wait_idle();
    repeat (2) @(negedge ap_clk);
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
